// File: rtl/spart_tx.sv
// rtl/spart_tx.sv - SPART transmit stage: one-entry holding register and 8N1 serializer (optional SPART_TX_PARITY_EN)
module spart_tx #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic [7:0]           write_line,
    input  logic                 transmit_write_enable,
    output logic                 tbr,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 tx_overrun
);

`ifdef SPART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state_q;
    logic [7:0]           hold_q;
    logic                 valid_q;
    logic [7:0]           shift_q;
    logic [2:0]           bit_cnt_q;
    logic [DIV_WIDTH-1:0] baud_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic                 txd_q;
    logic                 busy_q;
    logic                 overrun_q;
`ifdef SPART_TX_PARITY_EN
    logic                 parity_q;
`endif

    logic bit_end;
    logic load;

    // End of the current bit period, and whether a held byte enters the shifter at this edge
    always_comb begin
        bit_end = (baud_q == div_q);
        load    = valid_q && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
    end

    // Holding register, frame sequencing and registered line outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_q    <= 8'h00;
            valid_q   <= 1'b0;
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            baud_q    <= '0;
            div_q     <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SPART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            // A write only lands when the flag was clear before this edge; otherwise it is lost
            overrun_q <= transmit_write_enable && valid_q;
            if (transmit_write_enable && !valid_q) begin
                hold_q  <= write_line;
                valid_q <= 1'b1;
            end

            if (load) begin
                shift_q   <= hold_q;
                valid_q   <= 1'b0;
                div_q     <= divisor;
                baud_q    <= '0;
                bit_cnt_q <= 3'd0;
                state_q   <= START;
                txd_q     <= 1'b0;
                busy_q    <= 1'b1;
`ifdef SPART_TX_PARITY_EN
                parity_q  <= ^hold_q;
`endif
            end else if (state_q != IDLE) begin
                if (bit_end) begin
                    baud_q <= '0;
                    case (state_q)
                        START: begin
                            state_q <= DATA;
                            txd_q   <= shift_q[0];
                        end
                        DATA: begin
                            shift_q <= {1'b0, shift_q[7:1]};
                            if (bit_cnt_q == 3'd7) begin
                                bit_cnt_q <= 3'd0;
`ifdef SPART_TX_PARITY_EN
                                state_q   <= PARITY;
                                txd_q     <= parity_q;
`else
                                state_q   <= STOP;
                                txd_q     <= 1'b1;
`endif
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                txd_q     <= shift_q[1];
                            end
                        end
`ifdef SPART_TX_PARITY_EN
                        PARITY: begin
                            state_q <= STOP;
                            txd_q   <= 1'b1;
                        end
`endif
                        STOP: begin
                            state_q <= IDLE;
                            txd_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                        default: begin
                            state_q <= IDLE;
                            txd_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    endcase
                end else begin
                    baud_q <= baud_q + DIV_WIDTH'(1);
                end
            end
        end
    end

    // Status and line outputs straight from registers
    always_comb begin
        tbr        = !valid_q;
        txd        = txd_q;
        tx_busy    = busy_q;
        tx_overrun = overrun_q;
    end

endmodule

// File: tb/tb_spart_tx.sv
// tb/tb_spart_tx.sv - self-checking bench for spart_tx against a bit-queue line model
module tb_spart_tx;
    localparam int DW = 4;
`ifdef SPART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] divisor = '0;
    logic [7:0]    write_line = 8'h00;
    logic          transmit_write_enable = 1'b0;
    logic          tbr, txd, tx_busy, tx_overrun;

    spart_tx #(.DIV_WIDTH(DW)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .divisor               (divisor),
        .write_line            (write_line),
        .transmit_write_enable (transmit_write_enable),
        .tbr                   (tbr),
        .txd                   (txd),
        .tx_busy               (tx_busy),
        .tx_overrun            (tx_overrun)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference: the line is a queue of per-cycle txd values; a frame is appended whole when loaded
    logic       m_valid = 1'b0;
    logic [7:0] m_hold  = 8'h00;
    logic       q[$];
    logic       e_txd = 1'b1, e_tbr = 1'b1, e_busy = 1'b0, e_ovr = 1'b0;

    int busy_cnt, ovr_cnt;

    task automatic chk(string tag, logic obs, logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk_int(string tag, int obs, int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_edge(logic r, logic w, logic [7:0] d, logic [DW-1:0] dv);
        logic       pv;
        logic [7:0] b;
        logic       frame[$];
        if (r) begin
            q.delete();
            m_valid = 1'b0;
            e_txd = 1'b1; e_tbr = 1'b1; e_busy = 1'b0; e_ovr = 1'b0;
            return;
        end
        pv    = m_valid;
        e_ovr = w && pv;
        if (w && !pv) begin
            m_valid = 1'b1;
            m_hold  = d;
        end
        if (q.size() == 0 && pv) begin
            b = m_hold;
            m_valid = 1'b0;
            frame.push_back(1'b0);
            for (int i = 0; i < 8; i++) frame.push_back(b[i]);
            if (NB == 11) frame.push_back(^b);
            frame.push_back(1'b1);
            foreach (frame[i])
                for (int k = 0; k <= int'(dv); k++) q.push_back(frame[i]);
        end
        if (q.size() > 0) begin
            e_txd  = q.pop_front();
            e_busy = 1'b1;
        end else begin
            e_txd  = 1'b1;
            e_busy = 1'b0;
        end
        e_tbr = !m_valid;
    endtask

    task automatic cyc(logic w, logic [7:0] d);
        @(negedge clk);
        transmit_write_enable = w;
        write_line = d;
        @(posedge clk);
        model_edge(rst, w, d, divisor);
        #1;
        chk("txd", txd, e_txd);
        chk("tbr", tbr, e_tbr);
        chk("tx_busy", tx_busy, e_busy);
        chk("tx_overrun", tx_overrun, e_ovr);
        if (tx_busy) busy_cnt++;
        if (tx_overrun) ovr_cnt++;
        transmit_write_enable = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
    endtask

    initial begin
        // Reset then quiet line
        rst = 1'b1;
        cyc(1'b0, 8'h00);
        rst = 1'b0;
        busy_cnt = 0; ovr_cnt = 0;
        idle(20);
        chk_int("idle_busy_cycles", busy_cnt, 0);

        // 0xA5 at divisor 3
        divisor = 4'd3;
        busy_cnt = 0;
        cyc(1'b1, 8'hA5);
        idle(50);
        chk_int("a5_busy_cycles", busy_cnt, NB * 4);

        // Back-to-back frames at divisor 0
        divisor = 4'd0;
        busy_cnt = 0; ovr_cnt = 0;
        cyc(1'b1, 8'h3C);
        cyc(1'b0, 8'h00);
        cyc(1'b1, 8'hFF);
        idle(30);
        chk_int("b2b_busy_cycles", busy_cnt, 2 * NB);
        chk_int("b2b_overruns", ovr_cnt, 0);

        // Overrun while holding is full
        divisor = 4'd1;
        ovr_cnt = 0;
        cyc(1'b1, 8'h01);
        cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h02);
        cyc(1'b1, 8'h03);
        idle(60);
        chk_int("overrun_pulses", ovr_cnt, 1);

        // Divisor change mid-frame takes effect on the next frame
        divisor = 4'd2;
        busy_cnt = 0;
        cyc(1'b1, 8'h55);
        idle(10);
        divisor = 4'd7;
        cyc(1'b1, 8'h12);
        idle(150);
        chk_int("divchg_busy_cycles", busy_cnt, NB * 3 + NB * 8);

        // Reset during 4th data bit with holding full
        divisor = 4'd2;
        cyc(1'b1, 8'hF0);
        cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h77);
        idle(11);
        rst = 1'b1;
        cyc(1'b0, 8'h00);
        rst = 1'b0;
        busy_cnt = 0;
        idle(60);
        chk_int("post_reset_busy_cycles", busy_cnt, 0);

        // Maximum divisor: 2^DW cycles per bit
        divisor = 4'd15;
        busy_cnt = 0;
        cyc(1'b1, 8'hC3);
        idle(NB * 16 + 5);
        chk_int("maxdiv_busy_cycles", busy_cnt, NB * 16);

        // Randomized traffic with occasional divisor changes and one reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) divisor = DW'($urandom_range(0, 3));
            rst = (i == 1500);
            cyc(($urandom_range(0, 5) == 0), 8'($urandom));
        end
        rst = 1'b0;
        idle(NB * 4 + 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/spart_tx.md
# spart_tx

Transmit stage of the SPART. Accepts bytes from the bus interface through a one-entry holding register and serializes them on `txd` as 8N1 asynchronous frames, LSB first, at a bit rate set by a programmable divisor. It sits directly downstream of the bus interface: it consumes `write_line` and `transmit_write_enable`, and it returns `tbr` for status reads.

## Interface
- `DIV_WIDTH`, default 16: width of the baud divisor.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `divisor`  in  DIV_WIDTH  bit period minus one, in `clk` cycles. Driven by the baud registers.
- `write_line`  in  8  byte to transmit.
- `transmit_write_enable`  in  1  one-cycle strobe; loads `write_line` when `tbr`=1.
- `tbr`  out  1  transmit buffer ready; high means the holding register is empty.
- `txd`  out  1  serial output; idles high.
- `tx_busy`  out  1  high while a frame is on the line (any state other than IDLE).
- `tx_overrun`  out  1  one-cycle pulse when a write arrives while `tbr`=0; that write is dropped.

## Operation
- Storage:
  - 8-bit holding register with a valid flag. `tbr` = !valid.
  - 8-bit shift register.
  - bit counter, 0..7.
  - baud counter, DIV_WIDTH bits.
  - latched divisor.
- FSM states: IDLE, START, DATA, PARITY (only when the configuration macro is defined), STOP. Reset state is IDLE.
- Write: if `transmit_write_enable`=1 and `tbr`=1 at an edge, the holding register gets `write_line` and valid is set. If `tbr`=0, the write is ignored and `tx_overrun` pulses for one cycle.
- IDLE: if valid=1, then at the next edge:
  - the shift register gets the holding register and valid clears;
  - `divisor` is latched;
  - the baud counter clears;
  - the FSM goes to START.
- Each non-IDLE state lasts exactly latched_divisor+1 cycles. The baud counter counts up and the state advances when it equals the latched divisor; the counter then returns to 0.
- `txd` is a registered output:
  - START: 0.
  - DATA: shift[0]. The register shifts right at the end of each bit period. DATA repeats for 8 bits, with the bit counter wrapping 7→0.
  - PARITY: even parity of the byte.
  - STOP: 1.
  - IDLE: 1.
- End of STOP:
  - if valid=1: reload as in IDLE and go straight to START. Frames are back-to-back with no idle cycle.
  - otherwise: go to IDLE.
- `divisor` changes mid-frame have no effect until the next frame load.
- `divisor`=0 gives 1 cycle per bit. The maximum value gives 2^DIV_WIDTH cycles per bit.

## Timing
- Reset values (after the reset edge): `txd`=1, `tbr`=1, `tx_busy`=0, `tx_overrun`=0, state IDLE, valid=0, all counters 0.
- Reset mid-frame aborts the frame. `txd` is 1 from the cycle after the reset edge, and the holding data is discarded.
- Write sampled at edge E0 with the block idle:
  - `tbr`=0 after E0.
  - At E1 the transfer occurs: `tbr`=1 and `tx_busy`=1 after E1, and `txd`=0 from E1.
  - Write-to-start-bit latency is 2 edges.
- Frame length is 10×(D+1) cycles without parity and 11×(D+1) with parity.
- A write at the same edge as a frame-start transfer sees `tbr`=0 and is dropped. This holds because `tbr` is the registered flag before the transfer.
- With valid=1 during a frame, a second write is an overrun.
- `tx_busy` falls at the final STOP edge only when no frame follows.

## Configuration
- `SPART_TX_PARITY_EN`:
  - Defined: the PARITY state is inserted between DATA and STOP. It transmits even parity (XOR of the 8 data bits) for one bit period, giving an 11-bit frame.
  - Undefined: the PARITY state and its logic are absent, and the frame is 8N1 with 10 bits.
- No port differences either way.

## Test plan
- Reset, then idle 20 cycles → `txd`=1, `tbr`=1, `tx_busy`=0, `tx_overrun`=0 throughout.
- `divisor`=3, write 0xA5 at E0 → `txd`=0 for cycles 1–4 after E1, then bits 1,0,1,0,0,1,0,1, each 4 cycles, then stop=1 for 4 cycles. `tx_busy` high for 40 cycles. With parity enabled: parity bit 0, 44 cycles.
- `divisor`=0, write 0x3C, then write 0xFF while `tbr`=1 during the frame → second frame starts on the cycle right after the first stop bit. Total 20 busy cycles, no overrun.
- `divisor`=1, write 0x01, 0x02, then 0x03 while holding is full → 0x03 dropped, `tx_overrun` high for exactly 1 cycle, only 0x01 and 0x02 appear on `txd`.
- `divisor` changed from 2 to 7 during the DATA phase of 0x55 → current frame keeps 3-cycle bits, and the next frame uses 8-cycle bits.
- Assert `rst` for 1 cycle in the 4th data bit of 0xF0 with holding full → `txd`=1, `tbr`=1, `tx_busy`=0 next cycle, and no further frame is sent.
